// File: rtl/crc_pkg.sv
// Shared constants and state encoding for the CRC-3 generator and checker cores.
// Any change to the polynomial must be made here so both cores stay bit-identical.
package crc_pkg;

  localparam int              CRC_W    = 3;
  localparam logic [CRC_W-1:0] CRC_POLY = 3'b101;  // x^3 + x^2 + 1
  localparam int              DATA_W   = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } crc_state_t;

endpackage

// File: rtl/crc3_step.sv
// One MSB-first LFSR step of the CRC-3. Purely combinational so it can be chained
// several times in one cycle.
module crc3_step
  import crc_pkg::*;
(
  input  logic [CRC_W-1:0] i_crc,
  input  logic             i_d,
  output logic [CRC_W-1:0] o_crc
);

  logic w_fb;

  assign w_fb  = i_crc[CRC_W-1] ^ i_d;
  assign o_crc = {i_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : {CRC_W{1'b0}});

endmodule

// File: rtl/crc_check_core.sv
// Receive-side CRC-3 checker: recomputes the CRC of a 128-bit payload BPC bits per
// enabled cycle and reports the syndrome against the received CRC.
module crc_check_core
  import crc_pkg::*;
#(
  parameter int BPC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [DATA_W-1:0] data_in,
  input  logic [CRC_W-1:0]  crc_in,
  output logic [DATA_W-1:0] data_out,
  output logic              crc_ok,
  output logic              busy,
  output logic              done
);

  localparam int N_CHUNKS = DATA_W / BPC;
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8)) begin : g_bad_bpc
    $error("crc_check_core: BPC must be 1, 2, 4 or 8");
  end

  crc_state_t        r_state;
  crc_state_t        w_state_next;
  logic [DATA_W-1:0] r_data;
  logic [CRC_W-1:0]  r_rx_crc;
  logic [CRC_W-1:0]  r_crc;
  logic [CNT_W-1:0]  r_cnt;
  logic [CRC_W-1:0]  r_syndrome;
  logic              r_crc_ok;
  logic              w_last;
  logic [CRC_W-1:0]  w_crc_next;
  logic [CRC_W-1:0]  w_chain [0:BPC];

  // Chain BPC single-bit steps over the top BPC payload bits, MSB first.
  assign w_chain[0] = r_crc;
  for (genvar g = 0; g < BPC; g++) begin : g_step
    crc3_step u_step (
      .i_crc (w_chain[g]),
      .i_d   (r_data[DATA_W-1-g]),
      .o_crc (w_chain[g+1])
    );
  end
  assign w_crc_next = w_chain[BPC];

  assign w_last = (r_cnt == CNT_W'(N_CHUNKS - 1));

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (en) begin
      case (r_state)
        ST_IDLE:    if (start) w_state_next = ST_COMPUTE;
        ST_COMPUTE: if (w_last) w_state_next = ST_DONE;
        ST_DONE:    w_state_next = ST_IDLE;
        default:    w_state_next = ST_IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data     <= '0;
      r_rx_crc   <= '0;
      r_crc      <= '0;
      r_cnt      <= '0;
      r_syndrome <= '0;
      r_crc_ok   <= 1'b0;
    end else if (en) begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_data     <= data_in;
            r_rx_crc   <= crc_in;
            r_crc      <= '0;
            r_cnt      <= '0;
            r_syndrome <= '0;
            r_crc_ok   <= 1'b0;
          end
        end
        ST_COMPUTE: begin
          r_crc  <= w_crc_next;
          r_data <= r_data << BPC;
          // Counter holds at the terminal value instead of wrapping.
          if (w_last) begin
            r_syndrome <= w_crc_next ^ r_rx_crc;
            r_crc_ok   <= (w_crc_next == r_rx_crc);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out = {{(DATA_W-CRC_W){1'b0}}, r_syndrome};
  assign crc_ok   = r_crc_ok;
  assign done     = (r_state == ST_DONE);
  assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_crc_check_core.sv
// Directed bench for crc_check_core: BPC=1 and BPC=8 instances sharing clock,
// reset, enable and payload inputs, each with its own start.
module tb_crc_check_core;

  logic         clk;
  logic         rst;
  logic         en;
  logic         start_1, start_8;
  logic [127:0] data_in;
  logic [2:0]   crc_in;
  logic [127:0] data_out_1, data_out_8;
  logic         crc_ok_1, crc_ok_8, busy_1, busy_8, done_1, done_8;

  int n_cmp = 0;
  int n_err = 0;

  crc_check_core #(.BPC(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .start(start_1), .data_in(data_in), .crc_in(crc_in),
    .data_out(data_out_1), .crc_ok(crc_ok_1), .busy(busy_1), .done(done_1)
  );

  crc_check_core #(.BPC(8)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .start(start_8), .data_in(data_in), .crc_in(crc_in),
    .data_out(data_out_8), .crc_ok(crc_ok_8), .busy(busy_8), .done(done_8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Reference: remainder of data*x^3 divided by x^3+x^2+1 (long division).
  function automatic logic [2:0] ref_crc(input logic [127:0] d);
    logic [130:0] r;
    r = {d, 3'b000};
    for (int i = 130; i >= 3; i--)
      if (r[i]) r[i -: 4] = r[i -: 4] ^ 4'b1101;
    return r[2:0];
  endfunction

  function automatic logic get_done(input bit sel8);
    return sel8 ? done_8 : done_1;
  endfunction

  function automatic logic get_busy(input bit sel8);
    return sel8 ? busy_8 : busy_1;
  endfunction

  function automatic logic get_ok(input bit sel8);
    return sel8 ? crc_ok_8 : crc_ok_1;
  endfunction

  function automatic logic [127:0] get_dout(input bit sel8);
    return sel8 ? data_out_8 : data_out_1;
  endfunction

  // Starts one check just after an edge and counts edges from the capture edge
  // until done is seen. Optional stall window, start re-assertion and reset.
  task automatic run(input bit sel8, input logic [127:0] d, input logic [2:0] c,
                     input int stall_at, input int stall_len, input int restart_at,
                     input int rst_at, output int lat, output bit seen);
    data_in = d;
    crc_in  = c;
    if (sel8) start_8 = 1'b1; else start_1 = 1'b1;
    @(posedge clk); #1;
    start_1 = 1'b0;
    start_8 = 1'b0;
    check("busy_after_capture", get_busy(sel8), 1'b1);
    lat  = 0;
    seen = 1'b0;
    while (lat < 400 && !seen) begin
      if (lat == rst_at) begin
        rst = 1'b1;
        break;
      end
      if (lat == stall_at) en = 1'b0;
      if (lat == stall_at + stall_len) en = 1'b1;
      if (lat == restart_at) begin
        if (sel8) start_8 = 1'b1; else start_1 = 1'b1;
      end
      if (lat == restart_at + 3) begin
        start_1 = 1'b0;
        start_8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (get_done(sel8)) seen = 1'b1;
    end
    if (seen) begin
      check("done_busy", get_busy(sel8), 1'b1);
      @(posedge clk); #1;
      check("done_one_cycle", get_done(sel8), 1'b0);
      check("idle_after_done", get_busy(sel8), 1'b0);
    end
  endtask

  typedef struct {
    logic [127:0] d;
    logic [2:0]   c;
    logic         ok;
    logic [2:0]   syn;
  } vec_t;

  initial begin
    vec_t         vecs [4];
    int           lat;
    bit           seen;
    logic [127:0] d, d2;
    logic [2:0]   c;
    int           stray;

    rst = 1'b1; en = 1'b1; start_1 = 1'b0; start_8 = 1'b0;
    data_in = '0; crc_in = '0;

    // Reset state, then idle with start low.
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", done_1, 1'b0);
    check("rst_busy", busy_1, 1'b0);
    check("rst_ok", crc_ok_1, 1'b0);
    check("rst_dout", data_out_1, 128'h0);
    rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("idle_busy", busy_1, 1'b0);
    check("idle_done", done_1, 1'b0);

    // Zero payload, BPC=1.
    run(1'b0, 128'h0, 3'b000, -100, 0, -100, -100, lat, seen);
    check("zero_seen", seen, 1'b1);
    check("zero_latency", lat, 128);
    check("zero_ok", crc_ok_1, 1'b1);
    check("zero_syndrome", data_out_1, 128'h0);

    // Hand-computed vectors, including one bad CRC.
    vecs[0] = '{128'h1, 3'b101, 1'b1, 3'b000};
    vecs[1] = '{128'h2, 3'b111, 1'b1, 3'b000};
    vecs[2] = '{128'h3, 3'b010, 1'b1, 3'b000};
    vecs[3] = '{128'h1, 3'b100, 1'b0, 3'b001};
    foreach (vecs[i]) begin
      run(1'b0, vecs[i].d, vecs[i].c, -100, 0, -100, -100, lat, seen);
      check($sformatf("vec%0d_seen", i), seen, 1'b1);
      check($sformatf("vec%0d_ok", i), crc_ok_1, vecs[i].ok);
      check($sformatf("vec%0d_dout", i), data_out_1, {125'd0, vecs[i].syn});
    end

    // Results hold while idle.
    repeat (4) @(posedge clk);
    #1;
    check("hold_dout", data_out_1, 128'h1);
    check("hold_ok", crc_ok_1, 1'b0);

    // BPC=8 random payloads: good CRC, then a single flipped bit.
    for (int k = 0; k < 3; k++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      c = ref_crc(d);
      run(1'b1, d, c, -100, 0, -100, -100, lat, seen);
      check($sformatf("b8_%0d_latency", k), lat, 16);
      check($sformatf("b8_%0d_ok", k), crc_ok_8, 1'b1);
      check($sformatf("b8_%0d_dout", k), data_out_8, 128'h0);
      d2 = d;
      d2[$urandom_range(127, 0)] ^= 1'b1;
      run(1'b1, d2, c, -100, 0, -100, -100, lat, seen);
      check($sformatf("b8_%0d_flip_ok", k), crc_ok_8, 1'b0);
      check($sformatf("b8_%0d_flip_dout", k), data_out_8, {125'd0, ref_crc(d2) ^ c});
    end

    // en low for 5 cycles and start re-asserted mid-COMPUTE.
    run(1'b0, 128'h3, 3'b010, 10, 5, 20, -100, lat, seen);
    check("stall_latency", lat, 133);
    check("stall_ok", crc_ok_1, 1'b1);
    check("stall_dout", data_out_1, 128'h0);

    // Flip to a bad result so the reset clearing is visible.
    run(1'b0, 128'h1, 3'b100, -100, 0, -100, -100, lat, seen);
    check("pre_rst_dout", data_out_1, 128'h1);

    // Reset 50 cycles into a check: abort, no done pulse.
    run(1'b0, 128'h2, 3'b000, -100, 0, -100, 50, lat, seen);
    #1;
    check("abort_no_done", seen, 1'b0);
    check("abort_done", done_1, 1'b0);
    check("abort_busy", busy_1, 1'b0);
    check("abort_ok", crc_ok_1, 1'b0);
    check("abort_dout", data_out_1, 128'h0);
    rst = 1'b0;
    stray = 0;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk); #1;
      if (done_1 || busy_1) stray++;
    end
    check("abort_quiet", stray, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/crc_check_core.md
Name: crc_check_core

Overview:
- Receive-side companion to the CRC-3 generator core in the crc/sort datapath.
- Takes a 128-bit payload and the 3-bit CRC that arrived with it, and recomputes the CRC serially, BPC bits per cycle, MSB first.
- Reports the syndrome (computed XOR received) and a pass flag.
- Uses the same start/en/done handshake as the other function cores, so it can sit behind the same fn_sel multiplexer.

Parameters:
- BPC, 1: payload bits processed per enabled cycle. Legal values are 1, 2, 4, 8; any other value is an elaboration error.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset; asynchronous, active-high
- en  in  1  clock enable; when low, every register holds its value
- start  in  1  request; sampled only in IDLE with en=1
- data_in  in  128  payload; bit 127 is processed first
- crc_in  in  3  received CRC
- data_out  out  128  {125'd0, syndrome}
- crc_ok  out  1  1 when syndrome==0 for the last completed check
- busy  out  1  1 in COMPUTE or DONE
- done  out  1  single-cycle completion pulse

Behaviour:
- CRC definition: polynomial constant CRC_POLY=3'b101 (x^3+x^2+1). Initial CRC 3'b000. Per bit d: fb=crc[2]^d; crc={crc[1:0],1'b0}^(fb?CRC_POLY:3'b000). This is bit-identical to the generator.
- Reset (async): state=IDLE, crc_reg=0, cnt=0, data_reg=0, rx_crc=0, syndrome=0, crc_ok=0, done=0, busy=0.
- States are IDLE, COMPUTE, DONE.
- IDLE:
  - On an edge with en & start: data_reg<=data_in, rx_crc<=crc_in, crc_reg<=0, cnt<=0, state<=COMPUTE.
  - syndrome and crc_ok keep their previous results until this edge, then are cleared to 0.
- COMPUTE:
  - Each enabled edge applies BPC chained single-bit steps to data_reg[127:128-BPC].
  - data_reg shifts left by BPC; cnt increments.
  - On the edge where cnt==128/BPC-1 (the final chunk): syndrome<=crc_next^rx_crc, crc_ok<=(crc_next==rx_crc), state<=DONE.
- DONE: done=1 and busy=1 for exactly one enabled cycle; next enabled edge goes to IDLE.
- done is a decode of the registered state (no combinational path from inputs).
- Latency: with the start-capture edge as E0, done is high in the cycle after edge E_N, where N=128/BPC. For BPC=1 that is N=128; for BPC=8, N=16.
- en=0 at any point freezes state, counters, done and busy. Latency is extended by the number of disabled cycles.
- start outside IDLE is ignored and does not queue. start held high through DONE launches a new check only after IDLE is re-entered (one idle cycle minimum).
- Results (syndrome, crc_ok, data_out) stay stable from the final COMPUTE edge until the next accepted start.
- Reset mid-COMPUTE or in DONE aborts immediately. No done pulse is produced and all outputs return to their reset values.
- cnt width is clog2(128/BPC); the terminal compare prevents wrap.

Decomposition:
- Package crc_pkg: CRC_W=3, CRC_POLY=3'b101, DATA_W=128, state encoding (IDLE/COMPUTE/DONE). The generator core is retrofitted to the same package.
- Sub-module crc3_step: purely combinational one-bit LFSR step (crc, d -> crc_next). It is instantiated BPC times in a chain, and the generator can reuse it.

Test Plan:
- Reset then idle: rst pulse -> done=0, busy=0, crc_ok=0, data_out=0. No activity while start=0.
- Zero payload: data_in=0, crc_in=3'b000, BPC=1 -> done pulses 128 edges after capture; syndrome=000, crc_ok=1.
- Known vectors: data_in=128'h1 with crc_in=3'b101 -> crc_ok=1. data_in=128'h2 with crc_in=3'b111 -> crc_ok=1. data_in=128'h3 with crc_in=3'b010 -> crc_ok=1.
- Error detection: data_in=128'h1, crc_in=3'b100 -> syndrome=3'b001, crc_ok=0, data_out=128'h1.
- Width/latency sweep: BPC=8, random payloads, crc_in taken from a reference model -> crc_ok=1 with done at edge 16. Flipping a single data bit -> crc_ok=0.
- Control corners:
  - en low for 5 cycles mid-COMPUTE -> done delayed by exactly 5 cycles, result unchanged.
  - start re-asserted during COMPUTE -> ignored.
  - rst at cycle 50 -> no done pulse, outputs at reset values.
